// File: rtl/mem8x8_ctrl.sv
// mem8x8_ctrl: two-port round-robin arbiter and setup/access/hold sequencer
// for the 8x8 latch-based byte memory. The write data and operation are
// presented one cycle before the byte select rises and are held one cycle after
// it falls, so the latch bitcells never see data move while they are enabled.

// Invariant checker for the array-facing outputs.
module mem8x8_ctrl_chk (
  input logic       clk,
  input logic       rst,
  input logic       in_access,
  input logic [7:0] mem_sel,
  input logic [7:0] mem_inp,
  input logic [7:0] mem_inpn
);

  a_sel_onehot0: assert property (@(posedge clk) disable iff (rst)
    $onehot0(mem_sel));

  a_sel_only_in_access: assert property (@(posedge clk) disable iff (rst)
    (mem_sel != 8'h00) |-> in_access);

  a_inpn_complement: assert property (@(posedge clk) disable iff (rst)
    mem_inpn == ~mem_inp);

endmodule

module mem8x8_ctrl #(
  parameter int READ_WAIT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       op0,
  input  logic [2:0] addr0,
  input  logic [7:0] wdata0,
  output logic       gnt0,
  output logic       done0,
  input  logic       req1,
  input  logic       op1,
  input  logic [2:0] addr1,
  input  logic [7:0] wdata1,
  output logic       gnt1,
  output logic       done1,
  output logic [7:0] rdata,
  output logic [7:0] mem_sel,
  output logic       mem_op,
  output logic [7:0] mem_inp,
  output logic [7:0] mem_inpn,
  input  logic [7:0] mem_outp
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    HOLD   = 2'd3
  } state_t;

  // Counter reload for a read: the last ACCESS cycle is the one where it is 0.
  localparam logic [2:0] CNT_LOAD = 3'(READ_WAIT - 1);

  // One-hot byte select decode.
  function automatic logic [7:0] sel_decode(input logic [2:0] a);
    sel_decode = 8'h01 << a;
  endfunction

  state_t     state_r, state_s;
  logic       rr_last_r, rr_last_s;
  logic       own_r, own_s;
  logic       op_r, op_s;
  logic [2:0] addr_r, addr_s;
  logic [2:0] cnt_r, cnt_s;
  logic       gnt0_r, gnt0_s;
  logic       gnt1_r, gnt1_s;
  logic       done0_r, done0_s;
  logic       done1_r, done1_s;
  logic [7:0] rdata_r, rdata_s;
  logic [7:0] mem_sel_r, mem_sel_s;
  logic       mem_op_r, mem_op_s;
  logic [7:0] mem_inp_r, mem_inp_s;
  logic [7:0] mem_inpn_r;

  logic       pick1_s;
  logic       pick_op_s;
  logic [2:0] pick_addr_s;
  logic [7:0] pick_wdata_s;
  logic       in_access_s;

  // Arbitration: a lone requester wins; on a tie the port not granted last wins.
  always_comb begin
    pick1_s = req1 & (~req0 | ~rr_last_r);
    if (pick1_s) begin
      pick_op_s    = op1;
      pick_addr_s  = addr1;
      pick_wdata_s = wdata1;
    end else begin
      pick_op_s    = op0;
      pick_addr_s  = addr0;
      pick_wdata_s = wdata0;
    end
  end

  // Next-state and next-output logic; every output leaves through a register.
  always_comb begin
    state_s   = state_r;
    rr_last_s = rr_last_r;
    own_s     = own_r;
    op_s      = op_r;
    addr_s    = addr_r;
    cnt_s     = cnt_r;
    gnt0_s    = 1'b0;
    gnt1_s    = 1'b0;
    done0_s   = 1'b0;
    done1_s   = 1'b0;
    rdata_s   = rdata_r;
    mem_sel_s = 8'h00;
    mem_op_s  = mem_op_r;
    mem_inp_s = mem_inp_r;
    case (state_r)
      IDLE: begin
        mem_op_s  = 1'b0;
        mem_inp_s = 8'h00;
        if (req0 || req1) begin
          state_s   = SETUP;
          own_s     = pick1_s;
          rr_last_s = pick1_s;
          gnt0_s    = ~pick1_s;
          gnt1_s    = pick1_s;
          op_s      = pick_op_s;
          addr_s    = pick_addr_s;
          mem_op_s  = pick_op_s;
          if (pick_op_s) begin
            mem_inp_s = pick_wdata_s;
          end else begin
            mem_inp_s = 8'h00;
          end
        end else begin
          state_s = IDLE;
        end
      end
      SETUP: begin
        state_s   = ACCESS;
        mem_sel_s = sel_decode(addr_r);
        cnt_s     = CNT_LOAD;
      end
      ACCESS: begin
        if (op_r) begin
          state_s = HOLD;
        end else if (cnt_r != 3'd0) begin
          state_s   = ACCESS;
          cnt_s     = cnt_r - 3'd1;
          mem_sel_s = sel_decode(addr_r);
        end else begin
          state_s = HOLD;
          rdata_s = mem_outp;
        end
      end
      HOLD: begin
        state_s   = IDLE;
        done0_s   = ~own_r;
        done1_s   = own_r;
        mem_op_s  = 1'b0;
        mem_inp_s = 8'h00;
      end
      default: begin
        state_s   = IDLE;
        mem_op_s  = 1'b0;
        mem_inp_s = 8'h00;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last_r  <= 1'b1;
      own_r      <= 1'b0;
      op_r       <= 1'b0;
      addr_r     <= 3'd0;
      cnt_r      <= 3'd0;
      gnt0_r     <= 1'b0;
      gnt1_r     <= 1'b0;
      done0_r    <= 1'b0;
      done1_r    <= 1'b0;
      rdata_r    <= 8'h00;
      mem_sel_r  <= 8'h00;
      mem_op_r   <= 1'b0;
      mem_inp_r  <= 8'h00;
      mem_inpn_r <= 8'hFF;
    end else begin
      rr_last_r  <= rr_last_s;
      own_r      <= own_s;
      op_r       <= op_s;
      addr_r     <= addr_s;
      cnt_r      <= cnt_s;
      gnt0_r     <= gnt0_s;
      gnt1_r     <= gnt1_s;
      done0_r    <= done0_s;
      done1_r    <= done1_s;
      rdata_r    <= rdata_s;
      mem_sel_r  <= mem_sel_s;
      mem_op_r   <= mem_op_s;
      mem_inp_r  <= mem_inp_s;
      mem_inpn_r <= ~mem_inp_s;
    end
  end

  assign gnt0     = gnt0_r;
  assign gnt1     = gnt1_r;
  assign done0    = done0_r;
  assign done1    = done1_r;
  assign rdata    = rdata_r;
  assign mem_sel  = mem_sel_r;
  assign mem_op   = mem_op_r;
  assign mem_inp  = mem_inp_r;
  assign mem_inpn = mem_inpn_r;

  assign in_access_s = (state_r == ACCESS);

  mem8x8_ctrl_chk u_chk (
    .clk       (clk),
    .rst       (rst),
    .in_access (in_access_s),
    .mem_sel   (mem_sel_r),
    .mem_inp   (mem_inp_r),
    .mem_inpn  (mem_inpn_r)
  );

endmodule

// File: tb/tb_mem8x8_ctrl.sv
// Directed bench for mem8x8_ctrl (READ_WAIT = 2) with a behavioural 8x8 array.
module tb_mem8x8_ctrl;

  localparam int RW = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, op0, req1, op1;
  logic [2:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       gnt0, done0, gnt1, done1;
  logic [7:0] rdata, mem_sel, mem_inp, mem_inpn, mem_outp;
  logic       mem_op;

  int tests = 0;
  int fails = 0;

  logic [7:0] mem_m [8] = '{default: 8'h00};

  always #5 clk = ~clk;

  mem8x8_ctrl #(.READ_WAIT(RW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .op0(op0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .done0(done0),
    .req1(req1), .op1(op1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .done1(done1),
    .rdata(rdata), .mem_sel(mem_sel), .mem_op(mem_op), .mem_inp(mem_inp),
    .mem_inpn(mem_inpn), .mem_outp(mem_outp)
  );

  // Array model: write on the clock edge while selected, read combinationally.
  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (mem_op && mem_sel[i]) mem_m[i] <= mem_inp;
    end
  end

  // Array read path.
  always_comb begin
    mem_outp = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (mem_sel[i]) mem_outp = mem_m[i];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Issue one transaction on a port and measure gnt-to-done latency.
  task automatic do_txn(input logic p, input logic op, input logic [2:0] a,
                        input logic [7:0] d, input int exp_lat);
    int n;
    bit seen;
    if (p) begin
      req1 = 1'b1; op1 = op; addr1 = a; wdata1 = d;
    end else begin
      req0 = 1'b1; op0 = op; addr0 = a; wdata0 = d;
    end
    seen = 1'b0;
    n = 0;
    while (!seen && n < 10) begin
      cyc();
      n++;
      if ((p ? gnt1 : gnt0) === 1'b1) seen = 1'b1;
    end
    check("txn_gnt", 32'(seen), 32'd1);
    if (p) req1 = 1'b0;
    else   req0 = 1'b0;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 12) begin
      cyc();
      n++;
      if ((p ? done1 : done0) === 1'b1) seen = 1'b1;
    end
    check("txn_lat", 32'(n), 32'(exp_lat));
  endtask

  initial begin
    int g, dn, cn;
    logic last_owner;
    bit flag;

    rst = 1'b1;
    req0 = 1'b0; op0 = 1'b0; addr0 = 3'd0; wdata0 = 8'h00;
    req1 = 1'b0; op1 = 1'b0; addr1 = 3'd0; wdata1 = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset / idle state
    check("rst_sel",   32'(mem_sel),  32'h00);
    check("rst_inp",   32'(mem_inp),  32'h00);
    check("rst_inpn",  32'(mem_inpn), 32'hFF);
    check("rst_op",    32'(mem_op),   32'h0);
    check("rst_gnt",   32'({gnt0, gnt1}),   32'h0);
    check("rst_done",  32'({done0, done1}), 32'h0);
    check("rst_rdata", 32'(rdata),    32'h00);
    cyc();
    check("idle_gnt",  32'({gnt0, gnt1}), 32'h0);

    // Single write, port 0, addr 5, 0xA5
    req0 = 1'b1; op0 = 1'b1; addr0 = 3'd5; wdata0 = 8'hA5;
    cyc();
    check("wr_gnt0",       32'(gnt0),     32'h1);
    check("wr_setup_inp",  32'(mem_inp),  32'hA5);
    check("wr_setup_inpn", 32'(mem_inpn), 32'h5A);
    check("wr_setup_sel",  32'(mem_sel),  32'h00);
    check("wr_setup_op",   32'(mem_op),   32'h1);
    req0 = 1'b0;
    cyc();
    check("wr_acc_sel",  32'(mem_sel), 32'h20);
    check("wr_acc_op",   32'(mem_op),  32'h1);
    check("wr_gnt_pulse", 32'(gnt0),   32'h0);
    cyc();
    check("wr_hold_sel", 32'(mem_sel), 32'h00);
    check("wr_hold_inp", 32'(mem_inp), 32'hA5);
    cyc();
    check("wr_done0",    32'(done0),    32'h1);
    check("wr_done1",    32'(done1),    32'h0);
    check("wr_idle_op",  32'(mem_op),   32'h0);
    check("wr_idle_inp", 32'(mem_inpn), 32'hFF);
    check("wr_mem5",     32'(mem_m[5]), 32'hA5);

    // Read, port 1, addr 5 (READ_WAIT = 2)
    req1 = 1'b1; op1 = 1'b0; addr1 = 3'd5;
    cyc();
    check("rd_gnt1",      32'(gnt1),    32'h1);
    check("rd_setup_op",  32'(mem_op),  32'h0);
    check("rd_setup_inp", 32'(mem_inp), 32'h00);
    req1 = 1'b0;
    cyc();
    check("rd_acc1_sel", 32'(mem_sel), 32'h20);
    cyc();
    check("rd_acc2_sel", 32'(mem_sel), 32'h20);
    check("rd_acc2_op",  32'(mem_op),  32'h0);
    cyc();
    check("rd_hold_sel", 32'(mem_sel), 32'h00);
    check("rd_hold_done", 32'(done1),  32'h0);
    cyc();
    check("rd_done1", 32'(done1), 32'h1);
    check("rd_done0", 32'(done0), 32'h0);
    check("rd_rdata", 32'(rdata), 32'hA5);

    // Contention: both held high, writes to distinct addresses
    req0 = 1'b1; op0 = 1'b1; addr0 = 3'd1; wdata0 = 8'h11;
    req1 = 1'b1; op1 = 1'b1; addr1 = 3'd3; wdata1 = 8'h33;
    g = 0; dn = 0; cn = 0; last_owner = 1'b0;
    while (dn < 4 && cn < 60) begin
      cyc();
      cn++;
      if (gnt0 || gnt1) begin
        check("rr_order", 32'(gnt1), 32'(g % 2));
        last_owner = gnt1;
        g++;
        if (g == 4) begin
          req0 = 1'b0;
          req1 = 1'b0;
        end
      end
      if (done0 || done1) begin
        check("done_owner", 32'(done1), 32'(last_owner));
        dn++;
      end
    end
    check("rr_dones", 32'(dn), 32'd4);
    check("rr_mem1",  32'(mem_m[1]), 32'h11);
    check("rr_mem3",  32'(mem_m[3]), 32'h33);

    // Read back addr 3 on port 0, then a write must leave rdata alone
    do_txn(1'b0, 1'b0, 3'd3, 8'h00, 2 + RW);
    check("rd3_rdata", 32'(rdata), 32'h33);
    do_txn(1'b1, 1'b1, 3'd6, 8'hC3, 3);
    check("wr6_rdata_kept", 32'(rdata), 32'h33);
    check("wr6_mem",        32'(mem_m[6]), 32'hC3);

    // Reset mid-access: write addr 2 on port 0
    req0 = 1'b1; op0 = 1'b1; addr0 = 3'd2; wdata0 = 8'h5C;
    cyc();
    check("mr_gnt0", 32'(gnt0), 32'h1);
    req0 = 1'b0;
    cyc();
    check("mr_acc_sel", 32'(mem_sel), 32'h04);
    #2;
    rst = 1'b1;
    #1;
    check("mr_sel_async",  32'(mem_sel),  32'h00);
    check("mr_inpn_async", 32'(mem_inpn), 32'hFF);
    @(posedge clk);
    #1;
    rst = 1'b0;
    flag = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (done0 || done1) flag = 1'b1;
    end
    check("mr_no_done", 32'(flag), 32'h0);
    check("mr_mem2",    32'(mem_m[2]), 32'h00);

    // After reset the tie goes to port 0 again
    req0 = 1'b1; op0 = 1'b0; addr0 = 3'd1;
    req1 = 1'b1; op1 = 1'b0; addr1 = 3'd3;
    flag = 1'b0;
    cn = 0;
    while (!flag && cn < 10) begin
      cyc();
      cn++;
      if (gnt0 || gnt1) flag = 1'b1;
    end
    check("mr_regrant_seen", 32'(flag), 32'h1);
    check("mr_regrant_port", 32'({gnt0, gnt1}), 32'h2);
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (6) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
